// File: rtl/survivor_mem.sv
// survivor_mem: ring of D survivor words (S bits each) written by the ACS, with a zero-latency
// read port for the traceback unit and a small FSM that launches one traceback per step once
// the ring is full, blocking writes until the traceback unit has finished with the ring.
//
// Optional feature: define SURVIVOR_MEM_FORCE0_EN to honour wr_last (zero-terminated frames).
//   Defined:   tb_force_state0 = last_q during the launch; a wr_last launch refills from empty.
//   Undefined: tb_force_state0 = 0, wr_last ignored, traceback always returns to streaming.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   wr_valid/wr_ready         ACS step handshake
//   wr_surv[S]                survivor decision bits, bit i for state i
//   wr_best_state[M]          best-metric state of the step
//   wr_last                   final step of a zero-terminated frame
//   tb_start                  one-cycle traceback launch pulse
//   tb_start_time/state       slot and state the launch begins from
//   tb_force_state0           launch begins from state 0
//   tb_busy                   traceback unit busy
//   tb_time/tb_state          read address; tb_surv_bit is the addressed bit (0 if out of range)
module survivor_mem #(
    parameter int unsigned K = 7,
    parameter int unsigned M = K - 1,
    parameter int unsigned D = 40,
    localparam int unsigned S = 2 ** M,
    localparam int unsigned TIME_W = ($clog2(D) > 1) ? $clog2(D) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    input  logic [S-1:0]      wr_surv,
    input  logic [M-1:0]      wr_best_state,
    input  logic              wr_last,
    output logic              wr_ready,
    output logic              tb_start,
    output logic [TIME_W-1:0] tb_start_time,
    output logic [M-1:0]      tb_start_state,
    output logic              tb_force_state0,
    input  logic              tb_busy,
    input  logic [TIME_W-1:0] tb_time,
    input  logic [M-1:0]      tb_state,
    output logic              tb_surv_bit
);
    localparam int unsigned FILL_W = $clog2(D + 1);
    localparam int unsigned TIME_W1 = TIME_W + 1;
    localparam logic [TIME_W-1:0] LAST_PTR = TIME_W'(D - 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(D);
    localparam logic [FILL_W-1:0] FILL_ONE_SHORT = FILL_W'(D - 1);
    localparam logic [TIME_W:0] DEPTH = TIME_W1'(D);

    typedef enum logic [2:0] {StFill, StStream, StStart, StWaitBusy, StWaitDone} state_e;

    state_e              state_q, state_d;
    logic [TIME_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic [TIME_W-1:0]   tb_start_time_q, tb_start_time_d;
    logic [M-1:0]        tb_start_state_q, tb_start_state_d;
    logic                wr_en;
    logic                launch;
    logic [S-1:0]        mem_q [D];

`ifdef SURVIVOR_MEM_FORCE0_EN
    logic last_q, last_d;
`else
    logic unused_wr_last;
    assign unused_wr_last = wr_last;
`endif

    always_comb begin
        state_d          = state_q;
        wr_ptr_d         = wr_ptr_q;
        fill_d           = fill_q;
        tb_start_time_d  = tb_start_time_q;
        tb_start_state_d = tb_start_state_q;
`ifdef SURVIVOR_MEM_FORCE0_EN
        last_d           = last_q;
`endif
        wr_ready = (state_q == StFill) || (state_q == StStream);
        wr_en    = wr_valid && wr_ready;
        // In StStream fill is saturated, so only the filling write can match ONE_SHORT.
        launch   = wr_en && ((state_q == StStream) || (fill_q == FILL_ONE_SHORT));

        if (wr_en) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
            if (fill_q != FILL_FULL) begin
                fill_d = fill_q + 1'b1;
            end
        end

        unique case (state_q)
            StFill, StStream: begin
                if (launch) begin
                    state_d          = StStart;
                    tb_start_time_d  = wr_ptr_q;
                    tb_start_state_d = wr_best_state;
`ifdef SURVIVOR_MEM_FORCE0_EN
                    last_d           = wr_last;
`endif
                end
            end
            StStart: state_d = StWaitBusy;
            StWaitBusy: begin
                if (tb_busy) begin
                    state_d = StWaitDone;
                end
            end
            StWaitDone: begin
                if (!tb_busy) begin
                    state_d = StStream;
`ifdef SURVIVOR_MEM_FORCE0_EN
                    // End of a terminated frame: the ring must refill before the next launch.
                    if (last_q) begin
                        state_d = StFill;
                        fill_d  = '0;
                    end
`endif
                end
            end
            default: state_d = StFill;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= StFill;
            wr_ptr_q         <= '0;
            fill_q           <= '0;
            tb_start_time_q  <= '0;
            tb_start_state_q <= '0;
`ifdef SURVIVOR_MEM_FORCE0_EN
            last_q           <= 1'b0;
`endif
        end else begin
            state_q          <= state_d;
            wr_ptr_q         <= wr_ptr_d;
            fill_q           <= fill_d;
            tb_start_time_q  <= tb_start_time_d;
            tb_start_state_q <= tb_start_state_d;
`ifdef SURVIVOR_MEM_FORCE0_EN
            last_q           <= last_d;
`endif
        end
    end

    // Ring storage is deliberately not reset; fill gating keeps stale words unreachable.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_surv;
        end
    end

    always_comb begin
        tb_start        = (state_q == StStart);
        tb_start_time   = tb_start_time_q;
        tb_start_state  = tb_start_state_q;
`ifdef SURVIVOR_MEM_FORCE0_EN
        tb_force_state0 = (state_q == StStart) && last_q;
`else
        tb_force_state0 = 1'b0;
`endif
        tb_surv_bit     = 1'b0;
        if ({1'b0, tb_time} < DEPTH) begin
            tb_surv_bit = mem_q[tb_time][tb_state];
        end
    end

endmodule

// File: tb/tb_survivor_mem.sv
// Bench for survivor_mem with K=3 (S=4 states), D=4. A second instance with D=5 gives a
// 3-bit tb_time so out-of-range read slots can be exercised.
module tb_survivor_mem;
    localparam int K  = 3;
    localparam int M  = 2;
    localparam int S  = 4;
    localparam int D  = 4;
    localparam int TW = 2;
`ifdef SURVIVOR_MEM_FORCE0_EN
    localparam bit FORCE_EN = 1'b1;
`else
    localparam bit FORCE_EN = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          wr_valid;
    logic [S-1:0]  wr_surv;
    logic [M-1:0]  wr_best_state;
    logic          wr_last;
    logic          wr_ready;
    logic          tb_start;
    logic [TW-1:0] tb_start_time;
    logic [M-1:0]  tb_start_state;
    logic          tb_force_state0;
    logic          tb_busy;
    logic [TW-1:0] tb_time;
    logic [M-1:0]  tb_state;
    logic          tb_surv_bit;

    logic [2:0]    tb_time5;
    logic          tb_surv_bit5;
    logic          unused5_wr_ready;
    logic          unused5_tb_start;
    logic [2:0]    unused5_tb_start_time;
    logic [M-1:0]  unused5_tb_start_state;
    logic          unused5_tb_force_state0;

    int total;
    int bad;

    // Reference model: ring contents, write pointer and number of steps held since refill.
    logic [S-1:0] ref_mem [D];
    bit           ref_wr [D];
    int           ref_ptr;
    int           ref_fill;
    bit           ref_last;

    typedef struct {
        int   t;
        int   s;
        logic e;
    } rd_vec_t;
    rd_vec_t      vecs [16];
    logic [S-1:0] pat [D];

    survivor_mem #(.K(K), .D(D)) u_dut (
        .clk            (clk),
        .rst            (rst),
        .wr_valid       (wr_valid),
        .wr_surv        (wr_surv),
        .wr_best_state  (wr_best_state),
        .wr_last        (wr_last),
        .wr_ready       (wr_ready),
        .tb_start       (tb_start),
        .tb_start_time  (tb_start_time),
        .tb_start_state (tb_start_state),
        .tb_force_state0(tb_force_state0),
        .tb_busy        (tb_busy),
        .tb_time        (tb_time),
        .tb_state       (tb_state),
        .tb_surv_bit    (tb_surv_bit)
    );

    survivor_mem #(.K(K), .D(5)) u_dut5 (
        .clk            (clk),
        .rst            (rst),
        .wr_valid       (wr_valid),
        .wr_surv        (wr_surv),
        .wr_best_state  (wr_best_state),
        .wr_last        (wr_last),
        .wr_ready       (unused5_wr_ready),
        .tb_start       (unused5_tb_start),
        .tb_start_time  (unused5_tb_start_time),
        .tb_start_state (unused5_tb_start_state),
        .tb_force_state0(unused5_tb_force_state0),
        .tb_busy        (tb_busy),
        .tb_time        (tb_time5),
        .tb_state       (tb_state),
        .tb_surv_bit    (tb_surv_bit5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // One accepted step; the model predicts whether it launches a traceback.
    task automatic wr(input logic [S-1:0] surv, input logic [M-1:0] best, input logic last,
                      output bit launched);
        bit exp_l;
        exp_l = (ref_fill >= D - 1);
        chk("ready_before_write", wr_ready, 1);
        wr_valid      = 1'b1;
        wr_surv       = surv;
        wr_best_state = best;
        wr_last       = last;
        sync();
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        chk("start_after_write", tb_start, exp_l);
        if (exp_l) begin
            chk("launch_time", tb_start_time, ref_ptr);
            chk("launch_state", tb_start_state, best);
            chk("launch_force0", tb_force_state0, FORCE_EN && last);
            chk("ready_in_start", wr_ready, 0);
            ref_last = last;
        end else begin
            chk("force0_no_launch", tb_force_state0, 0);
            chk("ready_no_launch", wr_ready, 1);
        end
        ref_mem[ref_ptr] = surv;
        ref_wr[ref_ptr]  = 1'b1;
        ref_ptr          = (ref_ptr + 1) % D;
        if (ref_fill < D) ref_fill++;
        launched = exp_l;
    endtask

    // Traceback handshake after a launch; optionally hold junk on the write port meanwhile.
    task automatic trace(input int delay, input int hold, input bit stall);
        sync();
        chk("start_single_pulse", tb_start, 0);
        chk("ready_wait_busy", wr_ready, 0);
        for (int i = 0; i < delay; i++) begin
            sync();
            chk("ready_wait_busy", wr_ready, 0);
            chk("no_restart", tb_start, 0);
        end
        tb_busy = 1'b1;
        if (stall) begin
            wr_valid      = 1'b1;
            wr_surv       = S'($urandom);
            wr_best_state = M'($urandom);
            wr_last       = 1'($urandom);
        end
        for (int i = 0; i < hold; i++) begin
            sync();
            chk("ready_wait_done", wr_ready, 0);
            chk("no_restart", tb_start, 0);
        end
        tb_busy  = 1'b0;
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        sync();
        chk("ready_after_busy_falls", wr_ready, 1);
        chk("no_start_after_trace", tb_start, 0);
        if (FORCE_EN && ref_last) ref_fill = 0;
    endtask

    task automatic do_reset();
        #1 rst = 1'b1;
        #1;
        chk("rst_start", tb_start, 0);
        chk("rst_start_time", tb_start_time, 0);
        chk("rst_start_state", tb_start_state, 0);
        chk("rst_force0", tb_force_state0, 0);
        sync();
        rst = 1'b0;
        chk("ready_after_reset", wr_ready, 1);
        ref_ptr  = 0;
        ref_fill = 0;
    endtask

    task automatic rd(input int t, input int s, input logic e, input string nm);
        @(negedge clk);
        tb_time  = TW'(t);
        tb_state = M'(s);
        #1;
        chk(nm, tb_surv_bit, e);
    endtask

    task automatic rd_model(input int t, input int s);
        if (ref_wr[t]) rd(t, s, ref_mem[t][s], "read_model");
    endtask

    initial begin
        bit l;
        total = 0;
        bad   = 0;
        rst = 1'b1;
        wr_valid = 1'b0;
        wr_surv = '0;
        wr_best_state = '0;
        wr_last = 1'b0;
        tb_busy = 1'b0;
        tb_time = '0;
        tb_state = '0;
        tb_time5 = '0;
        ref_ptr = 0;
        ref_fill = 0;
        ref_last = 1'b0;
        for (int i = 0; i < D; i++) ref_wr[i] = 1'b0;
        pat[0] = 4'b0011;
        pat[1] = 4'b0110;
        pat[2] = 4'b1000;
        pat[3] = 4'b1101;
        for (int i = 0; i < 16; i++) begin
            vecs[i].t = i / 4;
            vecs[i].s = i % 4;
            vecs[i].e = pat[i / 4][i % 4];
        end

        repeat (2) @(posedge clk);
        #1;
        chk("rst_start", tb_start, 0);
        chk("rst_start_time", tb_start_time, 0);
        chk("rst_start_state", tb_start_state, 0);
        chk("rst_force0", tb_force_state0, 0);
        rst = 1'b0;
        chk("ready_after_reset", wr_ready, 1);

        // Three writes then reset: no launch; then four writes launch once from slot 3.
        for (int i = 0; i < 3; i++) wr(S'(4'hF), M'(i), 1'b1, l);
        do_reset();
        for (int i = 0; i < 4; i++) wr(pat[i], 2'd1, 1'b0, l);
        chk("first_launch_time3", tb_start_time, 3);
        trace(1, 2, 1'b0);

        // Read sweep against the known patterns, plus out-of-range slots on the D=5 copy.
        for (int i = 0; i < 16; i++) rd(vecs[i].t, vecs[i].s, vecs[i].e, "read_table");
        for (int t = 5; t < 8; t++) begin
            @(negedge clk);
            tb_time5 = 3'(t);
            tb_state = M'(t);
            #1;
            chk("read_out_of_range", tb_surv_bit5, 0);
        end
        sync();

        // Steady state: fifth write launches from slot 0; 40-cycle stall during WAIT_DONE.
        wr(4'b1010, 2'd2, 1'b0, l);
        chk("stream_launch_time0", tb_start_time, 0);
        chk("stream_launch_state2", tb_start_state, 2);
        trace(0, 40, 1'b1);
        for (int t = 0; t < D; t++) for (int s = 0; s < S; s++) rd_model(t, s);
        sync();
        wr(4'b0101, 2'd3, 1'b0, l);
        chk("no_ptr_advance_in_stall", tb_start_time, 1);
        trace(2, 1, 1'b1);

        // Reset in WAIT_BUSY abandons the launch; four fresh writes relaunch from slot 3.
        wr(4'b1111, 2'd0, 1'b0, l);
        sync();
        chk("in_wait_busy", wr_ready, 0);
        do_reset();
        for (int i = 0; i < 4; i++) wr(S'($urandom), M'($urandom), 1'b0, l);
        chk("relaunch_time3", tb_start_time, 3);
        trace(0, 1, 1'b0);

        // Frame end on the launching write.
        do_reset();
        for (int i = 0; i < 3; i++) wr(S'($urandom), M'(i), 1'b0, l);
        wr(S'($urandom), 2'd3, 1'b1, l);
        chk("last_launch", tb_start, 1);
        trace(1, 1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            wr(S'($urandom), M'($urandom), 1'b0, l);
            if (l) trace(0, 1, 1'b0);
        end

        // Randomised traffic against the model.
        for (int it = 0; it < 80; it++) begin
            int idle;
            idle = $urandom_range(0, 2);
            for (int j = 0; j < idle; j++) begin
                sync();
                chk("idle_no_start", tb_start, 0);
            end
            wr(S'($urandom), M'($urandom), $urandom_range(0, 4) == 0, l);
            if (l) trace($urandom_range(0, 3), $urandom_range(1, 4), 1'($urandom));
            rd_model($urandom_range(0, D - 1), $urandom_range(0, S - 1));
            rd_model($urandom_range(0, D - 1), $urandom_range(0, S - 1));
            sync();
            if ($urandom_range(0, 19) == 0) do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
